vs_inner_product_engine: RTL and testbench



---
 rtl/vs_inner_product_engine_pkg.sv | 49 ++++
 rtl/vs_inner_product_engine_if.sv | 43 ++++
 rtl/vs_inner_product_engine_mac.sv | 36 +++
 rtl/vs_inner_product_engine.sv | 117 +++++++++++
 tb/tb_vs_inner_product_engine.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vs_inner_product_engine_pkg.sv
// Shared types, constants and helpers for the inner-product engine.
// Q15 values live on 32-bit signed words.
package vs_inner_product_engine_pkg;

    localparam int FP_DATA_BUS_WIDTH = 32;
    localparam int FP_Q_DEFAULT = 15;
    localparam int SIGNAL_SIZE_DEFAULT = 16;
    localparam int DICTIONARY_SIZE_DEFAULT = 64;

    // Widest accumulator needed: M up to 256 rows.
    localparam int ACC_MAX_W = 2 * FP_DATA_BUS_WIDTH + 8 + 1;

    typedef logic signed [31:0] fp_32_t;
    typedef logic signed [63:0] fp_64_t;
    typedef logic signed [ACC_MAX_W-1:0] acc_max_t;

    localparam fp_32_t FP32_MAX = 32'sh7FFF_FFFF;
    localparam fp_32_t FP32_MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        IP_IDLE,
        IP_ISSUE,
        IP_DRAIN,
        IP_WRITE,
        IP_DONE
    } vs_ip_state_t;

    // Sum of m full-width products plus a sign bit never overflows.
    function automatic int vs_ip_acc_width(input int m);
        return 2 * FP_DATA_BUS_WIDTH + $clog2(m) + 1;
    endfunction

    // Floor shift by q fraction bits, then clamp to the 32-bit range.
    function automatic fp_32_t vs_fixed_acc_to_fp32(
        input acc_max_t acc,
        input int q = FP_Q_DEFAULT
    );
        acc_max_t sh;
        sh = acc >>> q;
        if (sh > acc_max_t'(FP32_MAX)) begin
            return FP32_MAX;
        end
        if (sh < acc_max_t'(FP32_MIN)) begin
            return FP32_MIN;
        end
        return sh[31:0];
    endfunction

endpackage

// File: rtl/vs_inner_product_engine_if.sv
// Command handshake plus y/dictionary read and x write ports.
// master = engine side, slave = environment (RAMs and controller).
interface vs_inner_product_engine_if;
    import vs_inner_product_engine_pkg::*;

    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  y_read_addr;
    fp_32_t      y_read_data;
    logic [15:0] dict_read_addr;
    fp_32_t      dict_read_data;
    logic        x_write_enable;
    logic [7:0]  x_write_addr;
    fp_32_t      x_write_data;

    modport master (
        input  start,
        input  y_read_data,
        input  dict_read_data,
        output busy,
        output done,
        output y_read_addr,
        output dict_read_addr,
        output x_write_enable,
        output x_write_addr,
        output x_write_data
    );

    modport slave (
        output start,
        output y_read_data,
        output dict_read_data,
        input  busy,
        input  done,
        input  y_read_addr,
        input  dict_read_addr,
        input  x_write_enable,
        input  x_write_addr,
        input  x_write_data
    );

endinterface

// File: rtl/vs_inner_product_engine_mac.sv
// Registered signed multiply-accumulate with clear and enable.
// The result is the accumulator floor-shifted and saturated to Q15.
module vs_fp_mac
    import vs_inner_product_engine_pkg::*;
#(
    parameter int ACC_W = vs_ip_acc_width(SIGNAL_SIZE_DEFAULT),
    parameter int FP_Q  = FP_Q_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   en,
    input  fp_32_t a,
    input  fp_32_t b,
    output fp_32_t result
);

    logic signed [ACC_W-1:0] acc;
    fp_64_t prod;

    assign prod = a * b;

    // Clear wins over accumulate; they are never requested together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    assign result = vs_fixed_acc_to_fp32(acc_max_t'(acc), FP_Q);

endmodule

// File: rtl/vs_inner_product_engine.sv
// Computes x[c] = sum_r D[c*M+r] * y[r] for every column c.
// One column costs M issue cycles, one drain and one write.
module vs_inner_product_engine
    import vs_inner_product_engine_pkg::*;
#(
    parameter int M    = SIGNAL_SIZE_DEFAULT,
    parameter int N    = DICTIONARY_SIZE_DEFAULT,
    parameter int FP_Q = FP_Q_DEFAULT
) (
    input logic clk,
    input logic reset,
    vs_inner_product_engine_if.master bus
);

    localparam int ACC_W = vs_ip_acc_width(M);

    vs_ip_state_t state_q, state_d;
    logic [7:0] r_q, r_d;
    logic [7:0] c_q, c_d;
    logic       en_q;
    logic       acc_clr;
    fp_32_t     result;

    logic issuing;
    logic writing;

    // State, counters and the one-cycle-late accumulate enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IP_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            en_q    <= (state_q == IP_ISSUE);
        end
    end

    // Next state, counter updates and accumulator clear.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        acc_clr = 1'b0;
        unique case (state_q)
            IP_IDLE: begin
                if (bus.start) begin
                    state_d = IP_ISSUE;
                    r_d     = '0;
                    c_d     = '0;
                    acc_clr = 1'b1;
                end
            end
            IP_ISSUE: begin
                if (r_q == 8'(M - 1)) begin
                    state_d = IP_DRAIN;
                    r_d     = '0;
                end else begin
                    r_d = r_q + 8'd1;
                end
            end
            IP_DRAIN: begin
                state_d = IP_WRITE;
            end
            IP_WRITE: begin
                acc_clr = 1'b1;
                r_d     = '0;
                if (c_q == 8'(N - 1)) begin
                    state_d = IP_DONE;
                end else begin
                    c_d     = c_q + 8'd1;
                    state_d = IP_ISSUE;
                end
            end
            IP_DONE: begin
                state_d = IP_IDLE;
            end
            default: begin
                state_d = IP_IDLE;
            end
        endcase
    end

    vs_fp_mac #(
        .ACC_W (ACC_W),
        .FP_Q  (FP_Q)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clr),
        .en     (en_q),
        .a      (bus.dict_read_data),
        .b      (bus.y_read_data),
        .result (result)
    );

    assign issuing = (state_q == IP_ISSUE);
    assign writing = (state_q == IP_WRITE);

    assign bus.busy = issuing
                    | (state_q == IP_DRAIN)
                    | writing;
    assign bus.done = (state_q == IP_DONE);

    assign bus.y_read_addr = issuing ? r_q : '0;
    assign bus.dict_read_addr = issuing
        ? 16'(c_q) * 16'(M) + 16'(r_q)
        : '0;

    assign bus.x_write_enable = writing;
    assign bus.x_write_addr   = writing ? c_q : '0;
    assign bus.x_write_data   = writing ? result : '0;

endmodule

// File: tb/tb_vs_inner_product_engine.sv
// Bench for vs_inner_product_engine: three instances with
// different shapes, RAM models and a reference inner product.
module tb_vs_inner_product_engine;
    import vs_inner_product_engine_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    vs_inner_product_engine_if bus_a ();
    vs_inner_product_engine_if bus_b ();
    vs_inner_product_engine_if bus_c ();

    vs_inner_product_engine #(.M(16), .N(64)) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a));
    vs_inner_product_engine #(.M(4), .N(2)) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b));
    vs_inner_product_engine #(.M(4), .N(1)) dut_c (
        .clk (clk), .reset (reset), .bus (bus_c));

    fp_32_t ya [256];
    fp_32_t yb [256];
    fp_32_t yc [256];
    fp_32_t da [65536];
    fp_32_t db [65536];
    fp_32_t dc [65536];

    fp_32_t my [256];
    fp_32_t md [65536];

    logic [7:0] wq_addr [$];
    fp_32_t     wq_data [$];
    int         done_cnt = 0;

    // Synchronous 1-cycle-latency read RAMs.
    always @(posedge clk) begin
        bus_a.y_read_data    <= ya[bus_a.y_read_addr];
        bus_a.dict_read_data <= da[bus_a.dict_read_addr];
        bus_b.y_read_data    <= yb[bus_b.y_read_addr];
        bus_b.dict_read_data <= db[bus_b.dict_read_addr];
        bus_c.y_read_data    <= yc[bus_c.y_read_addr];
        bus_c.dict_read_data <= dc[bus_c.dict_read_addr];
    end

    // x RAM write log and done pulse counter.
    always @(posedge clk) begin
        if (bus_a.x_write_enable) begin
            wq_addr.push_back(bus_a.x_write_addr);
            wq_data.push_back(bus_a.x_write_data);
        end
        if (bus_b.x_write_enable) begin
            wq_addr.push_back(bus_b.x_write_addr);
            wq_data.push_back(bus_b.x_write_data);
        end
        if (bus_c.x_write_enable) begin
            wq_addr.push_back(bus_c.x_write_addr);
            wq_data.push_back(bus_c.x_write_data);
        end
        if (bus_a.done || bus_b.done || bus_c.done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    // Reference: exact sum, floor shift by 15, clamp to 32 bits.
    function automatic fp_32_t model_x(int m, int c);
        logic signed [79:0] s;
        s = '0;
        for (int r = 0; r < m; r++) begin
            s = s + 80'(md[c * m + r]) * 80'(my[r]);
        end
        s = s >>> 15;
        if (s > 80'sd2147483647) return 32'sh7FFF_FFFF;
        if (s < -80'sd2147483648) return 32'sh8000_0000;
        return s[31:0];
    endfunction

    task automatic load(int id, int m, int n);
        for (int r = 0; r < m; r++) begin
            case (id)
                0: ya[r] = my[r];
                1: yb[r] = my[r];
                default: yc[r] = my[r];
            endcase
        end
        for (int i = 0; i < m * n; i++) begin
            case (id)
                0: da[i] = md[i];
                1: db[i] = md[i];
                default: dc[i] = md[i];
            endcase
        end
    endtask

    task automatic set_start(int id, logic v);
        case (id)
            0: bus_a.start = v;
            1: bus_b.start = v;
            default: bus_c.start = v;
        endcase
    endtask

    function automatic logic get_done(int id);
        case (id)
            0: return bus_a.done;
            1: return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    function automatic logic get_busy(int id);
        case (id)
            0: return bus_a.busy;
            1: return bus_b.busy;
            default: return bus_c.busy;
        endcase
    endfunction

    function automatic logic [66:0] get_outs(int id);
        case (id)
            0: return {bus_a.busy, bus_a.done,
                       bus_a.x_write_enable, bus_a.y_read_addr,
                       bus_a.dict_read_addr, bus_a.x_write_addr,
                       bus_a.x_write_data};
            1: return {bus_b.busy, bus_b.done,
                       bus_b.x_write_enable, bus_b.y_read_addr,
                       bus_b.dict_read_addr, bus_b.x_write_addr,
                       bus_b.x_write_data};
            default: return {bus_c.busy, bus_c.done,
                       bus_c.x_write_enable, bus_c.y_read_addr,
                       bus_c.dict_read_addr, bus_c.x_write_addr,
                       bus_c.x_write_data};
        endcase
    endfunction

    // Start a run; lat is the done cycle, start cycle being 0.
    // Extra start pulses are driven in cycles p1 and p2.
    task automatic run(int id, int p1, int p2,
                       output int lat, output bit tmo);
        set_start(id, 1'b1);
        @(posedge clk); #1;
        set_start(id, 1'b0);
        lat = 1;
        tmo = 1'b0;
        while (!get_done(id)) begin
            if (lat > 5000) begin
                tmo = 1'b1;
                break;
            end
            set_start(id, (lat == p1) || (lat == p2));
            @(posedge clk); #1;
            lat++;
        end
        set_start(id, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (get_outs(id) !== 67'd0) begin
                errors++;
                $display("FAIL reset_outs dut%0d got=%h exp=0",
                         id, get_outs(id));
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int id = 0; id < 3; id++) begin
            checks++;
            if (get_outs(id) !== 67'd0) begin
                errors++;
                $display("FAIL idle_outs dut%0d got=%h exp=0",
                         id, get_outs(id));
            end
        end
    endtask

    task automatic test_ones();
        int lat, base, dbase;
        bit tmo;
        for (int r = 0; r < 16; r++) my[r] = 32768;
        for (int i = 0; i < 1024; i++) md[i] = 16384;
        load(0, 16, 64);
        base = wq_addr.size();
        dbase = done_cnt;
        run(0, 0, 0, lat, tmo);
        checks++;
        if (tmo || lat != 1153) begin
            errors++;
            $display("FAIL ones_latency got=%0d exp=1153 tmo=%0d",
                     lat, tmo);
        end
        checks++;
        if (wq_addr.size() - base != 64) begin
            errors++;
            $display("FAIL ones_count got=%0d exp=64",
                     wq_addr.size() - base);
        end
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (base + c >= wq_addr.size() ||
                wq_addr[base + c] !== 8'(c) ||
                wq_data[base + c] !== 32'sd262144) begin
                errors++;
                $display("FAIL ones_x%0d exp=%0d", c, 262144);
            end
        end
        checks++;
        if (done_cnt - dbase != 1) begin
            errors++;
            $display("FAIL ones_done got=%0d exp=1",
                     done_cnt - dbase);
        end
    endtask

    task automatic test_signs();
        int lat, base;
        bit tmo;
        fp_32_t exp_x [2];
        exp_x[0] = -131072;
        exp_x[1] = 131072;
        for (int r = 0; r < 4; r++) my[r] = 32768;
        for (int i = 0; i < 4; i++) md[i] = -32768;
        for (int i = 4; i < 8; i++) md[i] = 32768;
        load(1, 4, 2);
        base = wq_addr.size();
        run(1, 0, 0, lat, tmo);
        checks++;
        if (tmo || lat != 13) begin
            errors++;
            $display("FAIL signs_latency got=%0d exp=13", lat);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (base + c >= wq_addr.size() ||
                wq_addr[base + c] !== 8'(c) ||
                wq_data[base + c] !== exp_x[c]) begin
                errors++;
                $display("FAIL signs_x%0d exp=%0d", c, exp_x[c]);
            end
        end
    endtask

    task automatic test_floor();
        int lat, base;
        bit tmo;
        fp_32_t exp_x;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) my[r] = 0;
            for (int i = 0; i < 4; i++) md[i] = 0;
            my[0] = 1;
            md[0] = (k == 0) ? -1 : 1;
            exp_x = (k == 0) ? -1 : 0;
            load(2, 4, 1);
            base = wq_addr.size();
            run(2, 0, 0, lat, tmo);
            checks++;
            if (tmo || wq_addr.size() - base != 1 ||
                wq_data[base] !== exp_x) begin
                errors++;
                $display("FAIL floor%0d got=%0d exp=%0d tmo=%0d",
                         k, wq_data[base], exp_x, tmo);
            end
        end
    endtask

    task automatic test_saturation();
        int lat, base;
        bit tmo;
        fp_32_t exp_x;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) my[r] = 32'sh7FFF_FFFF;
            for (int i = 0; i < 4; i++) begin
                md[i] = (k == 0) ? 32'sh7FFF_FFFF
                                 : 32'sh8000_0000;
            end
            exp_x = (k == 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
            load(2, 4, 1);
            base = wq_addr.size();
            run(2, 0, 0, lat, tmo);
            checks++;
            if (tmo || wq_addr.size() - base != 1 ||
                wq_data[base] !== exp_x) begin
                errors++;
                $display("FAIL sat%0d got=%h exp=%h tmo=%0d",
                         k, wq_data[base], exp_x, tmo);
            end
        end
    endtask

    task automatic fill_small(int m, int n);
        int v;
        for (int r = 0; r < m; r++) begin
            v = int'($urandom_range(262143)) - 131072;
            my[r] = v;
        end
        for (int i = 0; i < m * n; i++) begin
            v = int'($urandom_range(262143)) - 131072;
            md[i] = v;
        end
    endtask

    task automatic test_random();
        int lat, base;
        bit tmo;
        fill_small(16, 64);
        load(0, 16, 64);
        base = wq_addr.size();
        run(0, 0, 0, lat, tmo);
        checks++;
        if (tmo || wq_addr.size() - base != 64) begin
            errors++;
            $display("FAIL rand_count got=%0d exp=64",
                     wq_addr.size() - base);
        end
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (base + c >= wq_addr.size() ||
                wq_addr[base + c] !== 8'(c) ||
                wq_data[base + c] !== model_x(16, c)) begin
                errors++;
                $display("FAIL rand_x%0d exp=%0d", c, model_x(16, c));
            end
        end
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 4; r++) my[r] = $urandom();
            for (int i = 0; i < 4; i++) md[i] = $urandom();
            if (k >= 3) my[k - 3] = 0;
            load(2, 4, 1);
            base = wq_addr.size();
            run(2, 0, 0, lat, tmo);
            checks++;
            if (tmo || wq_addr.size() - base != 1 ||
                wq_data[base] !== model_x(4, 0)) begin
                errors++;
                $display("FAIL rand_c%0d got=%h exp=%h",
                         k, wq_data[base], model_x(4, 0));
            end
        end
    endtask

    task automatic test_start_busy();
        int lat, base, dbase;
        bit tmo;
        fill_small(16, 64);
        load(0, 16, 64);
        base = wq_addr.size();
        dbase = done_cnt;
        run(0, 5, 20, lat, tmo);
        checks++;
        if (tmo || lat != 1153) begin
            errors++;
            $display("FAIL busy_latency got=%0d exp=1153", lat);
        end
        checks++;
        if (done_cnt - dbase != 1 ||
            wq_addr.size() - base != 64) begin
            errors++;
            $display("FAIL busy_counts done=%0d writes=%0d exp=1/64",
                     done_cnt - dbase, wq_addr.size() - base);
        end
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (base + c >= wq_addr.size() ||
                wq_addr[base + c] !== 8'(c) ||
                wq_data[base + c] !== model_x(16, c)) begin
                errors++;
                $display("FAIL busy_x%0d exp=%0d", c, model_x(16, c));
            end
        end
        checks++;
        if (get_busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle got=%b exp=0", get_busy(0));
        end
    endtask

    task automatic test_reset_midrun();
        int n, base, wsz, lat;
        bit tmo;
        fill_small(16, 64);
        load(0, 16, 64);
        base = wq_addr.size();
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        n = 0;
        while (wq_addr.size() - base < 3 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL mid_wait got=timeout exp=3 writes");
        end
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (get_outs(0) !== 67'd0) begin
            errors++;
            $display("FAIL mid_outs got=%h exp=0", get_outs(0));
        end
        wsz = wq_addr.size();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (wq_addr.size() != wsz || wsz - base != 3 ||
            get_busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet writes=%0d exp=3 busy=%b",
                     wq_addr.size() - base, get_busy(0));
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wq_data[base + c] !== model_x(16, c)) begin
                errors++;
                $display("FAIL mid_part%0d got=%0d exp=%0d",
                         c, wq_data[base + c], model_x(16, c));
            end
        end
        base = wq_addr.size();
        run(0, 0, 0, lat, tmo);
        checks++;
        if (tmo || lat != 1153 || wq_addr.size() - base != 64) begin
            errors++;
            $display("FAIL mid_rerun lat=%0d writes=%0d exp=1153/64",
                     lat, wq_addr.size() - base);
        end
        for (int c = 0; c < 64; c++) begin
            checks++;
            if (base + c >= wq_addr.size() ||
                wq_addr[base + c] !== 8'(c) ||
                wq_data[base + c] !== model_x(16, c)) begin
                errors++;
                $display("FAIL mid_x%0d exp=%0d", c, model_x(16, c));
            end
        end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ya[i] = '0;
            yb[i] = '0;
            yc[i] = '0;
        end
        for (int i = 0; i < 1024; i++) begin
            da[i] = '0;
            db[i] = '0;
            dc[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ones();
        test_signs();
        test_floor();
        test_saturation();
        test_random();
        test_start_busy();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
